// File: rtl/verificador_desafio.sv
// rtl/verificador_desafio.sv - challenge verifier: walks an 8-word challenge ROM and scores each answer
//
// Purpose:
//   A start pulse begins a round of 8 challenges read from an external ROM.
//   Each 60-bit word holds either a 4-character password (opcode != 11) or a
//   sensor window (opcode = 11). The answer is checked and pulses acerto or
//   erro. Passed challenges are counted, and fim is raised after the eighth.
//
// Ports:
//   clock, reset_n          system clock, asynchronous active-low reset
//   iniciar                 start-of-round pulse (accepted only when idle or finished)
//   mem_address / mem_data  challenge ROM address and its combinational 60-bit word
//   char_valid, char_in     one-cycle strobe and 7-bit ASCII character
//   medida_valid, medida    one-cycle strobe and 12-bit (3 BCD digit) sensor reading
//   opcode, leds,           registered fields [59:58], [57:54], [53:52] of the
//   pos_inicial             current word
//   acerto, erro            one-cycle pass / fail pulses
//   acertos                 passed challenges in this round (0..8)
//   fim                     level, high once the round is complete
//
// Build option:
//   VERIFICADOR_TIMEOUT_EN  when defined, a challenge fails after TIMEOUT_CICLOS
//                           cycles of waiting. When undefined, waiting is unbounded.

module verificador_desafio #(
  parameter int TIMEOUT_CICLOS = 50000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        iniciar,
  output logic [2:0]  mem_address,
  input  logic [59:0] mem_data,
  input  logic        char_valid,
  input  logic [6:0]  char_in,
  input  logic        medida_valid,
  input  logic [11:0] medida,
  output logic [1:0]  opcode,
  output logic [3:0]  leds,
  output logic [1:0]  pos_inicial,
  output logic        acerto,
  output logic        erro,
  output logic [3:0]  acertos,
  output logic        fim
);

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    CARREGA   = 3'd1,
    ESPERA    = 3'd2,
    RESULTADO = 3'd3,
    PROXIMO   = 3'd4,
    FIM       = 3'd5
  } estado_t;

  estado_t     estado, prox_estado;

  logic [11:0] lim_inf, lim_sup;
  logic [27:0] esperado;
  logic [1:0]  indice;
  logic        passou;          // outcome latched for the RESULTADO cycle

  logic [6:0]  char_esperado;
  logic        modo_sensor;
  logic        decide, decide_ok;
  logic        avanca;
  logic        espera_decide, espera_ok;

  assign modo_sensor = (opcode == 2'b11);

  always_comb begin
    char_esperado = esperado[6:0];
    case (indice)
      2'd0:    char_esperado = esperado[6:0];
      2'd1:    char_esperado = esperado[13:7];
      2'd2:    char_esperado = esperado[20:14];
      default: char_esperado = esperado[27:21];
    endcase
  end

  // Decision from the strobe relevant to the current opcode. The other
  // strobe is ignored even when both arrive together.
  always_comb begin
    decide    = 1'b0;
    decide_ok = 1'b0;
    avanca    = 1'b0;
    if (estado == ESPERA) begin
      if (modo_sensor) begin
        if (medida_valid) begin
          decide    = 1'b1;
          decide_ok = (medida >= lim_inf) && (medida <= lim_sup);
        end
      end else if (char_valid) begin
        if (char_in != char_esperado) begin
          // No resynchronisation: any wrong character ends the challenge.
          decide = 1'b1;
        end else if (indice == 2'd3) begin
          decide    = 1'b1;
          decide_ok = 1'b1;
        end else begin
          avanca = 1'b1;
        end
      end
    end
  end

`ifdef VERIFICADOR_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;

  logic [CW-1:0] contador;
  logic          estouro;

  assign estouro = (estado == ESPERA) && (contador == CW'(TIMEOUT_CICLOS - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      contador <= '0;
    end else if (estado == CARREGA) begin
      contador <= '0;
    end else if (estado == ESPERA) begin
      contador <= contador + 1'b1;
    end
  end

  // A real answer in the expiry cycle wins over the timeout.
  assign espera_decide = decide | estouro;
  assign espera_ok     = decide & decide_ok;
`else
  assign espera_decide = decide;
  assign espera_ok     = decide_ok;
`endif

  always_comb begin
    prox_estado = estado;
    case (estado)
      OCIOSO, FIM: if (iniciar) prox_estado = CARREGA;
      CARREGA:     prox_estado = ESPERA;
      ESPERA:      if (espera_decide) prox_estado = RESULTADO;
      RESULTADO:   prox_estado = PROXIMO;
      PROXIMO:     prox_estado = (mem_address == 3'd7) ? FIM : CARREGA;
      default:     prox_estado = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) estado <= OCIOSO;
    else          estado <= prox_estado;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_address <= 3'd0;
      opcode      <= 2'd0;
      leds        <= 4'd0;
      pos_inicial <= 2'd0;
      lim_inf     <= 12'd0;
      lim_sup     <= 12'd0;
      esperado    <= 28'd0;
      indice      <= 2'd0;
      passou      <= 1'b0;
      acerto      <= 1'b0;
      erro        <= 1'b0;
      acertos     <= 4'd0;
      fim         <= 1'b0;
    end else begin
      // acerto/erro are high only for the RESULTADO cycle.
      acerto <= 1'b0;
      erro   <= 1'b0;
      case (estado)
        OCIOSO, FIM: begin
          if (iniciar) begin
            mem_address <= 3'd0;
            acertos     <= 4'd0;
            fim         <= 1'b0;
          end
        end
        CARREGA: begin
          opcode      <= mem_data[59:58];
          leds        <= mem_data[57:54];
          pos_inicial <= mem_data[53:52];
          lim_inf     <= mem_data[51:40];
          lim_sup     <= mem_data[39:28];
          esperado    <= mem_data[27:0];
          indice      <= 2'd0;
        end
        ESPERA: begin
          if (avanca) indice <= indice + 2'd1;
          if (espera_decide) begin
            passou <= espera_ok;
            acerto <= espera_ok;
            erro   <= ~espera_ok;
          end
        end
        RESULTADO: begin
          if (passou && (acertos != 4'd8)) acertos <= acertos + 4'd1;
        end
        PROXIMO: begin
          if (mem_address == 3'd7) fim <= 1'b1;
          else                     mem_address <= mem_address + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_verificador_desafio.sv
// tb/tb_verificador_desafio.sv - self-checking bench for verificador_desafio with a behavioural round model

module tb_verificador_desafio;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        iniciar = 1'b0;
  logic [2:0]  mem_address;
  logic [59:0] mem_data;
  logic        char_valid = 1'b0;
  logic [6:0]  char_in = 7'd0;
  logic        medida_valid = 1'b0;
  logic [11:0] medida = 12'd0;
  logic [1:0]  opcode;
  logic [3:0]  leds;
  logic [1:0]  pos_inicial;
  logic        acerto;
  logic        erro;
  logic [3:0]  acertos;
  logic        fim;

  int checks = 0;
  int errors = 0;

  logic [59:0] rom [8];

  localparam logic [6:0] C_HASH = 7'h23;
  localparam logic [6:0] C_1    = 7'h31;
  localparam logic [6:0] C_2    = 7'h32;
  localparam logic [6:0] C_DOL  = 7'h24;
  localparam logic [6:0] C_Y    = 7'h59;
  localparam logic [27:0] WORD_Y = {C_Y, C_DOL, C_1, C_HASH};

  always #5 clock = ~clock;

  assign mem_data = rom[mem_address];

  verificador_desafio #(.TIMEOUT_CICLOS(100)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .iniciar      (iniciar),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .char_valid   (char_valid),
    .char_in      (char_in),
    .medida_valid (medida_valid),
    .medida       (medida),
    .opcode       (opcode),
    .leds         (leds),
    .pos_inicial  (pos_inicial),
    .acerto       (acerto),
    .erro         (erro),
    .acertos      (acertos),
    .fim          (fim)
  );

  function automatic logic [59:0] mk_word(input logic [1:0] op, input logic [3:0] l,
                                          input logic [1:0] p, input logic [11:0] lo,
                                          input logic [11:0] hi, input logic [27:0] e);
    return {op, l, p, lo, hi, e};
  endfunction

  task automatic step();
    @(negedge clock);
  endtask

  task automatic strobe(input logic cv, input logic [6:0] c, input logic mv, input logic [11:0] m);
    char_valid = cv; char_in = c; medida_valid = mv; medida = m;
    step();
    char_valid = 1'b0; medida_valid = 1'b0;
  endtask

  task automatic do_reset();
    iniciar = 1'b0; char_valid = 1'b0; medida_valid = 1'b0;
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
  endtask

  // Ends at the first negedge inside ESPERA of challenge 0.
  task automatic start_round();
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    step();
  endtask

  task automatic send_word_y();
    strobe(1'b1, C_HASH, 1'b0, 12'd0);
    strobe(1'b1, C_1,    1'b0, 12'd0);
    strobe(1'b1, C_DOL,  1'b0, 12'd0);
    strobe(1'b1, C_Y,    1'b0, 12'd0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(); step();
    checks++;
    if ({mem_address, opcode, leds, pos_inicial, acerto, erro, acertos, fim} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0",
               {mem_address, opcode, leds, pos_inicial, acerto, erro, acertos, fim});
    end
    reset_n = 1'b1;
    step();
    strobe(1'b1, C_HASH, 1'b1, 12'h010);
    checks++;
    if (acerto !== 1'b0 || erro !== 1'b0 || mem_address !== 3'd0) begin
      errors++;
      $display("FAIL idle_strobe acerto=%b erro=%b addr=%0d want 0 0 0", acerto, erro, mem_address);
    end
  endtask

  task automatic test_word_chars();
    for (int k = 0; k < 8; k++) rom[k] = mk_word(2'b10, 4'(k + 1), 2'(k), 12'h0, 12'h0, WORD_Y);
    do_reset();
    start_round();
    checks++;
    if (opcode !== 2'b10 || leds !== 4'd1 || pos_inicial !== 2'd0) begin
      errors++;
      $display("FAIL word_fields got %b %h %0d want 10 1 0", opcode, leds, pos_inicial);
    end
    strobe(1'b1, C_HASH, 1'b0, 12'd0);
    strobe(1'b1, C_1,    1'b0, 12'd0);
    strobe(1'b1, C_DOL,  1'b0, 12'd0);
    checks++;
    if (acerto !== 1'b0 || erro !== 1'b0) begin
      errors++;
      $display("FAIL early_decision acerto=%b erro=%b want 0 0", acerto, erro);
    end
    strobe(1'b1, C_Y, 1'b0, 12'd0);
    checks++;
    if (acerto !== 1'b1 || erro !== 1'b0) begin
      errors++;
      $display("FAIL acerto_after_Y acerto=%b erro=%b want 1 0", acerto, erro);
    end
    step();
    checks++;
    if (acerto !== 1'b0 || acertos !== 4'd1) begin
      errors++;
      $display("FAIL acerto_pulse_width acerto=%b acertos=%0d want 0 1", acerto, acertos);
    end
    step(); step();
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    checks++;
    if (mem_address !== 3'd1 || leds !== 4'd2 || acertos !== 4'd1) begin
      errors++;
      $display("FAIL iniciar_ignored addr=%0d leds=%0d acertos=%0d want 1 2 1", mem_address, leds, acertos);
    end
    strobe(1'b1, C_HASH, 1'b0, 12'd0);
    strobe(1'b1, C_2,    1'b0, 12'd0);
    checks++;
    if (erro !== 1'b1 || acerto !== 1'b0) begin
      errors++;
      $display("FAIL erro_after_2 erro=%b acerto=%b want 1 0", erro, acerto);
    end
    strobe(1'b1, C_DOL, 1'b0, 12'd0);
    strobe(1'b1, C_Y,   1'b0, 12'd0);
    checks++;
    if (acerto !== 1'b0 || erro !== 1'b0 || mem_address !== 3'd2 || acertos !== 4'd1) begin
      errors++;
      $display("FAIL after_mismatch acerto=%b erro=%b addr=%0d acertos=%0d want 0 0 2 1",
               acerto, erro, mem_address, acertos);
    end
    step();
    send_word_y();
    checks++;
    if (acerto !== 1'b1) begin
      errors++;
      $display("FAIL next_challenge_clean acerto=%b want 1", acerto);
    end
  endtask

  task automatic test_sensor();
    rom[0] = mk_word(2'b11, 4'h5, 2'd1, 12'h010, 12'h025, WORD_Y);
    rom[1] = rom[0];
    rom[2] = mk_word(2'b01, 4'h6, 2'd2, 12'h010, 12'h025, WORD_Y);
    rom[3] = rom[0];
    rom[4] = rom[0];
    do_reset();
    start_round();
    checks++;
    if (opcode !== 2'b11 || leds !== 4'h5 || pos_inicial !== 2'd1) begin
      errors++;
      $display("FAIL sensor_fields got %b %h %0d want 11 5 1", opcode, leds, pos_inicial);
    end
    send_word_y();
    checks++;
    if (acerto !== 1'b0 || erro !== 1'b0) begin
      errors++;
      $display("FAIL sensor_chars_ignored acerto=%b erro=%b want 0 0", acerto, erro);
    end
    strobe(1'b1, C_HASH, 1'b1, 12'h010);
    checks++;
    if (acerto !== 1'b1 || erro !== 1'b0) begin
      errors++;
      $display("FAIL medida_010 acerto=%b erro=%b want 1 0", acerto, erro);
    end
    step(); step(); step();
    strobe(1'b1, C_HASH, 1'b1, 12'h026);
    checks++;
    if (acerto !== 1'b0 || erro !== 1'b1) begin
      errors++;
      $display("FAIL medida_026 acerto=%b erro=%b want 0 1", acerto, erro);
    end
    step(); step(); step();
    strobe(1'b0, 7'd0, 1'b1, 12'h015);
    checks++;
    if (acerto !== 1'b0 || erro !== 1'b0) begin
      errors++;
      $display("FAIL medida_ignored_char_mode acerto=%b erro=%b want 0 0", acerto, erro);
    end
    strobe(1'b1, C_HASH, 1'b1, 12'h015);
    strobe(1'b1, C_1,    1'b1, 12'h999);
    strobe(1'b1, C_DOL,  1'b1, 12'h015);
    strobe(1'b1, C_Y,    1'b1, 12'h999);
    checks++;
    if (acerto !== 1'b1 || erro !== 1'b0) begin
      errors++;
      $display("FAIL char_mode_with_medida acerto=%b erro=%b want 1 0", acerto, erro);
    end
    step(); step(); step();
    strobe(1'b0, 7'd0, 1'b1, 12'h025);
    checks++;
    if (acerto !== 1'b1) begin
      errors++;
      $display("FAIL medida_upper_bound acerto=%b want 1", acerto);
    end
    step(); step(); step();
    strobe(1'b0, 7'd0, 1'b1, 12'h00F);
    checks++;
    if (erro !== 1'b1) begin
      errors++;
      $display("FAIL medida_below_lower erro=%b want 1", erro);
    end
    step();
    checks++;
    if (acertos !== 4'd3) begin
      errors++;
      $display("FAIL sensor_acertos got %0d want 3", acertos);
    end
  endtask

  // One full round against a reference model: a challenge passes when the
  // sent characters equal the word's four characters in order (stopping at the
  // first difference), or when the reading falls inside [lo, hi].
  task automatic run_round(input bit all_correct);
    logic [1:0]  ops [8];
    logic [3:0]  lv  [8];
    logic [1:0]  pv  [8];
    logic [11:0] lo  [8];
    logic [11:0] hi  [8];
    logic [6:0]  tgt [8][4];
    int exp_acertos;
    exp_acertos = 0;
    for (int k = 0; k < 8; k++) begin
      logic [11:0] t;
      ops[k] = 2'($urandom_range(0, 3));
      lv[k]  = 4'($urandom);
      pv[k]  = 2'($urandom);
      lo[k]  = 12'($urandom);
      hi[k]  = 12'($urandom);
      if (lo[k] > hi[k]) begin t = lo[k]; lo[k] = hi[k]; hi[k] = t; end
      for (int j = 0; j < 4; j++) tgt[k][j] = 7'($urandom);
      rom[k] = mk_word(ops[k], lv[k], pv[k], lo[k], hi[k],
                       {tgt[k][3], tgt[k][2], tgt[k][1], tgt[k][0]});
    end
    start_round();
    checks++;
    if (fim !== 1'b0 || mem_address !== 3'd0 || acertos !== 4'd0) begin
      errors++;
      $display("FAIL round_start fim=%b addr=%0d acertos=%0d want 0 0 0", fim, mem_address, acertos);
    end
    for (int k = 0; k < 8; k++) begin
      bit pass;
      checks++;
      if ({opcode, leds, pos_inicial} !== {ops[k], lv[k], pv[k]} || mem_address !== 3'(k)) begin
        errors++;
        $display("FAIL load_%0d got %b/%h/%0d addr %0d want %b/%h/%0d addr %0d", k, opcode, leds,
                 pos_inicial, mem_address, ops[k], lv[k], pv[k], k);
      end
      if (ops[k] == 2'b11) begin
        logic [11:0] m;
        int sel;
        sel = $urandom_range(0, 4);
        if (all_correct)   m = 12'($urandom_range(int'(lo[k]), int'(hi[k])));
        else if (sel == 0) m = lo[k];
        else if (sel == 1) m = hi[k];
        else if (sel == 2) m = lo[k] - 12'd1;
        else if (sel == 3) m = hi[k] + 12'd1;
        else               m = 12'($urandom);
        pass = (int'(m) >= int'(lo[k])) && (int'(m) <= int'(hi[k]));
        for (int n = $urandom_range(0, 2); n > 0; n--) begin
          strobe(1'b1, 7'($urandom), 1'b0, 12'd0);
          checks++;
          if (acerto !== 1'b0 || erro !== 1'b0) begin
            errors++;
            $display("FAIL sensor_noise_%0d acerto=%b erro=%b want 0 0", k, acerto, erro);
          end
        end
        strobe(1'($urandom_range(0, 1)), 7'($urandom), 1'b1, m);
        checks++;
        if (acerto !== pass || erro !== !pass) begin
          errors++;
          $display("FAIL sensor_%0d m=%h acerto=%b erro=%b want %b %b", k, m, acerto, erro, pass, !pass);
        end
      end else begin
        logic [6:0] sent [4];
        int bad, decided_at;
        bad = all_correct ? 4 : $urandom_range(0, 4);
        for (int j = 0; j < 4; j++)
          sent[j] = (j == bad) ? (tgt[k][j] ^ 7'($urandom_range(1, 127))) : tgt[k][j];
        decided_at = 3;
        pass = 1'b1;
        for (int j = 0; j < 4; j++) begin
          if (sent[j] !== tgt[k][j]) begin decided_at = j; pass = 1'b0; break; end
        end
        for (int j = 0; j <= decided_at; j++) begin
          for (int g = $urandom_range(0, 2); g > 0; g--) begin
            strobe(1'b0, 7'd0, 1'($urandom_range(0, 1)), 12'($urandom));
            checks++;
            if (acerto !== 1'b0 || erro !== 1'b0) begin
              errors++;
              $display("FAIL char_gap_%0d acerto=%b erro=%b want 0 0", k, acerto, erro);
            end
          end
          strobe(1'b1, sent[j], 1'($urandom_range(0, 1)), 12'($urandom));
          checks++;
          if (j == decided_at) begin
            if (acerto !== pass || erro !== !pass) begin
              errors++;
              $display("FAIL char_%0d_%0d acerto=%b erro=%b want %b %b", k, j, acerto, erro, pass, !pass);
            end
          end else if (acerto !== 1'b0 || erro !== 1'b0) begin
            errors++;
            $display("FAIL char_%0d_%0d acerto=%b erro=%b want 0 0", k, j, acerto, erro);
          end
        end
      end
      if (pass && exp_acertos < 8) exp_acertos++;
      step();
      checks++;
      if (acertos !== 4'(exp_acertos)) begin
        errors++;
        $display("FAIL acertos_%0d got %0d want %0d", k, acertos, exp_acertos);
      end
      if (k < 7) begin
        step(); step();
      end
    end
    step();
    checks++;
    if (fim !== 1'b1 || mem_address !== 3'd7) begin
      errors++;
      $display("FAIL round_end fim=%b addr=%0d want 1 7", fim, mem_address);
    end
    for (int n = 0; n < 3; n++) strobe(1'($urandom_range(0, 1)), 7'($urandom), 1'($urandom_range(0, 1)), 12'($urandom));
    checks++;
    if (fim !== 1'b1 || mem_address !== 3'd7 || acertos !== 4'(exp_acertos) || acerto !== 1'b0 || erro !== 1'b0) begin
      errors++;
      $display("FAIL fim_hold fim=%b addr=%0d acertos=%0d pulses=%b%b want 1 7 %0d 00",
               fim, mem_address, acertos, acerto, erro, exp_acertos);
    end
  endtask

  task automatic test_full_round();
    do_reset();
    run_round(1'b1);
    checks++;
    if (acertos !== 4'd8) begin
      errors++;
      $display("FAIL full_round_acertos got %0d want 8", acertos);
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) run_round(1'b0);
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 8; k++) rom[k] = mk_word(2'b10, 4'(k + 1), 2'(k), 12'h0, 12'h0, WORD_Y);
    do_reset();
    start_round();
    send_word_y();
    step(); step(); step();
    strobe(1'b1, C_HASH, 1'b0, 12'd0);
    strobe(1'b1, C_1,    1'b0, 12'd0);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_address, opcode, leds, pos_inicial, acerto, erro, acertos, fim} !== 18'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs got %h want 0",
               {mem_address, opcode, leds, pos_inicial, acerto, erro, acertos, fim});
    end
    step();
    reset_n = 1'b1;
    step();
    start_round();
    checks++;
    if (mem_address !== 3'd0 || acertos !== 4'd0 || leds !== 4'd1) begin
      errors++;
      $display("FAIL restart addr=%0d acertos=%0d leds=%0d want 0 0 1", mem_address, acertos, leds);
    end
    send_word_y();
    checks++;
    if (acerto !== 1'b1 || erro !== 1'b0) begin
      errors++;
      $display("FAIL restart_index acerto=%b erro=%b want 1 0", acerto, erro);
    end
  endtask

  task automatic test_timeout();
    bit early;
    for (int k = 0; k < 8; k++) rom[k] = mk_word(2'b10, 4'(k + 1), 2'(k), 12'h0, 12'h0, WORD_Y);
    do_reset();
    start_round();
    early = 1'b0;
`ifdef VERIFICADOR_TIMEOUT_EN
    for (int c = 0; c < 99; c++) begin
      step();
      if (acerto !== 1'b0 || erro !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL timeout_early got early=1 want 0");
    end
    step();
    checks++;
    if (erro !== 1'b1 || acerto !== 1'b0) begin
      errors++;
      $display("FAIL timeout_erro erro=%b acerto=%b want 1 0", erro, acerto);
    end
    step(); step(); step();
    strobe(1'b1, C_HASH, 1'b0, 12'd0);
    strobe(1'b1, C_1,    1'b0, 12'd0);
    strobe(1'b1, C_DOL,  1'b0, 12'd0);
    for (int c = 0; c < 96; c++) step();
    strobe(1'b1, C_Y, 1'b0, 12'd0);
    checks++;
    if (acerto !== 1'b1 || erro !== 1'b0) begin
      errors++;
      $display("FAIL timeout_priority acerto=%b erro=%b want 1 0", acerto, erro);
    end
`else
    for (int c = 0; c < 1000; c++) begin
      step();
      if (acerto !== 1'b0 || erro !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL no_timeout got decision=1 want 0");
    end
    send_word_y();
    checks++;
    if (acerto !== 1'b1 || mem_address !== 3'd0) begin
      errors++;
      $display("FAIL after_long_wait acerto=%b addr=%0d want 1 0", acerto, mem_address);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_word_chars();
    test_sensor();
    test_full_round();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
